// File: rtl/register_file_dump_if.sv
// Read port 2 of the register file plus the {index, data} beat stream of the dump engine.
interface register_file_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              rf_port_req;
  logic              rf_port_gnt;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Dump engine: drives the read port and sources beats.
  modport master (
    output rf_port_req,
    output rf_read_addr,
    input  rf_port_gnt,
    input  rf_read_data,
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Register file / pipeline arbiter and beat sink.
  modport slave (
    input  rf_port_req,
    input  rf_read_addr,
    output rf_port_gnt,
    output rf_read_data,
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/register_file_dump.sv
// Debug engine that walks a register range through read port 2 and streams {index, data} beats.
module register_file_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    start_index_i,
  input  logic [ADDR_W-1:0]    end_index_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  register_file_dump_if.master bus
);

  localparam int unsigned LAST_REG = NUM_REGS - 1;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {IDLE, ARB, SCAN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;

  logic [ADDR_W-1:0] next_idx_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] infl_idx_q;
  logic              infl_q;
  logic              infl_last_q;

  logic [ADDR_W-1:0] buf_idx_q  [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic              buf_last_q [DEPTH];
  logic              rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] end_clamp_c;
  logic              accept_c;
  logic              empty_rng_c;
  logic              flush_c;
  logic              pop_c;
  logic [CNT_W-1:0]  left_c;
  logic              room_c;
  logic              issue_c;
  logic              issue_last_c;
  logic              drain_done_c;

  // An end index beyond the register file is treated as the last register, so next_idx never wraps.
  assign end_clamp_c  = (32'(end_index_i) > LAST_REG) ? ADDR_W'(LAST_REG) : end_index_i;
  assign accept_c     = (state_q == IDLE) && start_i && !abort_i && (start_index_i <= end_clamp_c);
  assign empty_rng_c  = (state_q == IDLE) && start_i && !abort_i && (start_index_i >  end_clamp_c);
  assign flush_c      = abort_i && (state_q != IDLE);

  // A beat leaving this cycle frees its slot, which is what lets the scan sustain one beat per cycle.
  assign pop_c        = bus.out_valid && bus.out_ready;
  assign left_c       = count_q - CNT_W'(pop_c);
  assign room_c       = (left_c + CNT_W'(infl_q)) < CNT_W'(DEPTH);
  assign issue_c      = (state_q == SCAN) && !abort_i && bus.rf_port_gnt && room_c;
  assign issue_last_c = issue_c && (next_idx_q == end_q);
  assign drain_done_c = !infl_q && (left_c == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ARB;
      ARB:     if (abort_i) state_d = IDLE;
               else if (bus.rf_port_gnt) state_d = SCAN;
      SCAN:    if (abort_i) state_d = IDLE;
               else if (issue_last_c) state_d = DRAIN;
      DRAIN:   if (abort_i || drain_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, computed from the next state so the flops line up with it.
  always_comb begin
    busy_d = 1'b0;
    req_d  = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    req_d  = (state_d == ARB) || (state_d == SCAN);
    done_d = empty_rng_c || ((state_q == DRAIN) && !abort_i && drain_done_c);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      req_q  <= req_d;
    end
  end

  // Scan pointer, issued address and the single in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_idx_q  <= '0;
      end_q       <= '0;
      addr_q      <= '0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      infl_q      <= 1'b0;
    end else begin
      if (accept_c) begin
        next_idx_q <= start_index_i;
        end_q      <= end_clamp_c;
      end
      if (issue_c) begin
        addr_q      <= next_idx_q;
        infl_idx_q  <= next_idx_q;
        infl_last_q <= issue_last_c;
        if (!issue_last_c) next_idx_q <= next_idx_q + ADDR_W'(1);
      end
      infl_q <= issue_c;
    end
  end

  // Two-entry beat buffer absorbing the one-cycle read latency; capture does not depend on the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_idx_q[i]  <= '0;
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_c) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (infl_q) begin
        buf_idx_q[wr_ptr_q]  <= infl_idx_q;
        buf_data_q[wr_ptr_q] <= bus.rf_read_data;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + CNT_W'(infl_q) - CNT_W'(pop_c);
    end
  end

  // The read address follows the scan pointer only on an issue cycle and otherwise holds.
  assign bus.rf_read_addr = issue_c ? next_idx_q : addr_q;
  assign bus.rf_port_req  = req_q;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_index    = buf_idx_q[rd_ptr_q];
  assign bus.out_data     = buf_data_q[rd_ptr_q];
  assign bus.out_last     = buf_last_q[rd_ptr_q];
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule
